// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 720p timing defaults, geometry constants shared with the
// pixel-colour stage, and helpers deriving axis totals and sync windows.
package vga_timing_pkg;

    // 1280x720 @ 60 Hz defaults (74.25 MHz pixel clock)
    localparam int H_ACTIVE_720P = 1280;
    localparam int H_FP_720P     = 110;
    localparam int H_SYNC_720P   = 40;
    localparam int H_BP_720P     = 220;
    localparam int V_ACTIVE_720P = 720;
    localparam int V_FP_720P     = 5;
    localparam int V_SYNC_720P   = 5;
    localparam int V_BP_720P     = 20;

    // Geometry and colour format seen by the pixel-colour stage
    localparam int SCREEN_WIDTH  = H_ACTIVE_720P;
    localparam int SCREEN_HEIGHT = V_ACTIVE_720P;
    localparam int COLOUR_BITS   = 8;

    // Counter widths of the top-level outputs
    localparam int H_CNT_W = 11;
    localparam int V_CNT_W = 10;

    // Full period of one axis (pixels per line or lines per frame)
    function automatic int axis_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // First position of the sync pulse on an axis
    function automatic int sync_first(input int active, input int fp);
        return active + fp;
    endfunction

    // Last position of the sync pulse on an axis (inclusive)
    function automatic int sync_last(input int active, input int fp, input int sync);
        return active + fp + sync - 1;
    endfunction

endpackage

// File: rtl/vga_timing_gen_axis_counter.sv
// vga_axis_counter: one raster axis. count is registered; wrap/active/sync
// are combinational and describe the value count takes at the next edge, so
// the parent can register flags that line up with the counter.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = H_ACTIVE_720P,
    parameter int FP     = H_FP_720P,
    parameter int SYNC   = H_SYNC_720P,
    parameter int BP     = H_BP_720P,
    parameter int WIDTH  = H_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_advance,
    output logic [WIDTH-1:0] o_count,
    output logic             o_wrap,
    output logic             o_active,
    output logic             o_sync
);

    localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
    localparam logic [WIDTH-1:0] LAST_V   = WIDTH'(TOTAL - 1);
    localparam logic [WIDTH-1:0] ACTIVE_V = WIDTH'(ACTIVE);
    localparam logic [WIDTH-1:0] SYNC_LO  = WIDTH'(sync_first(ACTIVE, FP));
    localparam logic [WIDTH-1:0] SYNC_HI  = WIDTH'(sync_last(ACTIVE, FP, SYNC));

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_next;
    logic             w_wrap;

    // Next count and the flags describing it
    always_comb begin
        w_wrap = 1'b0;
        w_next = r_count;
        if (i_advance) begin
            if (r_count == LAST_V) begin
                w_wrap = 1'b1;
                w_next = {WIDTH{1'b0}};
            end else begin
                w_next = r_count + {{(WIDTH-1){1'b0}}, 1'b1};
            end
        end else begin
            w_next = r_count;
        end
    end

    // Counter register; parks on the last position so the first edge out of reset lands on 0
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= LAST_V;
        end else begin
            r_count <= w_next;
        end
    end

    assign o_count  = r_count;
    assign o_wrap   = w_wrap;
    assign o_active = (w_next < ACTIVE_V);
    assign o_sync   = (w_next >= SYNC_LO) && (w_next <= SYNC_HI);

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing for the 1280x720 UI panel, pixel_clk domain.
// Every output is a flop. Optional build macro VGA_SYNC_ALIGN_EN adds one
// register stage on hsync/vsync so they lag the counters by one pixel.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE  = H_ACTIVE_720P,
    parameter int H_FP      = H_FP_720P,
    parameter int H_SYNC    = H_SYNC_720P,
    parameter int H_BP      = H_BP_720P,
    parameter int V_ACTIVE  = V_ACTIVE_720P,
    parameter int V_FP      = V_FP_720P,
    parameter int V_SYNC    = V_SYNC_720P,
    parameter int V_BP      = V_BP_720P,
    parameter bit HSYNC_POL = 1'b1,
    parameter bit VSYNC_POL = 1'b1
) (
    input  logic               pixel_clk,
    input  logic               reset,
    output logic [H_CNT_W-1:0] h_counter,
    output logic [V_CNT_W-1:0] v_counter,
    output logic               display_enable,
    output logic               hsync,
    output logic               vsync,
    output logic               line_start,
    output logic               frame_start,
    output logic [7:0]         frame_count
);

    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if ((H_TOTAL > 2048) || (V_TOTAL > 1024) ||
        (H_ACTIVE == 0) || (H_FP == 0) || (H_SYNC == 0) || (H_BP == 0) ||
        (V_ACTIVE == 0) || (V_FP == 0) || (V_SYNC == 0) || (V_BP == 0)) begin : g_bad_params
        $error("vga_timing_gen: timing parameters out of range");
    end

    logic w_h_wrap, w_h_active, w_h_sync;
    logic w_v_wrap, w_v_active, w_v_sync;
    logic r_display_enable, r_hsync, r_vsync, r_line_start, r_frame_start;
    logic [7:0] r_frame_count;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE), .FP (H_FP), .SYNC (H_SYNC), .BP (H_BP), .WIDTH (H_CNT_W)
    ) u_h_axis (
        .i_clk     (pixel_clk),
        .i_rst     (reset),
        .i_advance (1'b1),
        .o_count   (h_counter),
        .o_wrap    (w_h_wrap),
        .o_active  (w_h_active),
        .o_sync    (w_h_sync)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE), .FP (V_FP), .SYNC (V_SYNC), .BP (V_BP), .WIDTH (V_CNT_W)
    ) u_v_axis (
        .i_clk     (pixel_clk),
        .i_rst     (reset),
        .i_advance (w_h_wrap),
        .o_count   (v_counter),
        .o_wrap    (w_v_wrap),
        .o_active  (w_v_active),
        .o_sync    (w_v_sync)
    );

    // Flags registered from next-count values so they describe the (h,v) shown alongside them
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            r_display_enable <= 1'b0;
            r_hsync          <= ~HSYNC_POL;
            r_vsync          <= ~VSYNC_POL;
            r_line_start     <= 1'b0;
            r_frame_start    <= 1'b0;
        end else begin
            r_display_enable <= w_h_active & w_v_active;
            r_hsync          <= w_h_sync ? HSYNC_POL : ~HSYNC_POL;
            r_vsync          <= w_v_sync ? VSYNC_POL : ~VSYNC_POL;
            r_line_start     <= w_h_wrap;
            r_frame_start    <= w_h_wrap & w_v_wrap;
        end
    end

    // Frame counter steps on the cycle after each frame_start pulse
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            r_frame_count <= 8'd0;
        end else if (r_frame_start) begin
            r_frame_count <= r_frame_count + 8'd1;
        end else begin
            r_frame_count <= r_frame_count;
        end
    end

`ifdef VGA_SYNC_ALIGN_EN
    logic r_hsync_d, r_vsync_d;

    // Extra sync stage matching a registered RGB output downstream
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            r_hsync_d <= ~HSYNC_POL;
            r_vsync_d <= ~VSYNC_POL;
        end else begin
            r_hsync_d <= r_hsync;
            r_vsync_d <= r_vsync;
        end
    end

    assign hsync = r_hsync_d;
    assign vsync = r_vsync_d;
`else
    assign hsync = r_hsync;
    assign vsync = r_vsync;
`endif

    assign display_enable = r_display_enable;
    assign line_start     = r_line_start;
    assign frame_start    = r_frame_start;
    assign frame_count    = r_frame_count;

endmodule
